vy_hakem: RTL and testbench
===========================

Name: vy_hakem

Overview:
- Two-requester arbiter sharing one veri yolu (memory bus) port between the L1 instruction cache controller (requester 0, l1b) and the L1 data cache controller (requester 1, l1v).
- Accepts one block-granular read or write from one requester at a time, forwards it downstream, and routes the read response back to the owner.
- Exactly one transaction is outstanding at any time.

Parameters:
- ADRES_BIT, 32, request address width.
- BLOK_BIT, 128, cache block width (one request or response beat).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- k_istek_adres_i  in  2*ADRES_BIT  requester addresses; slice [r*ADRES_BIT +: ADRES_BIT].
- k_istek_gecerli_i  in  2  per-requester request valid.
- k_istek_yaz_i  in  2  per-requester write flag (1 = write, 0 = read).
- k_istek_veri_i  in  2*BLOK_BIT  per-requester write block.
- k_istek_hazir_o  out  2  per-requester request ready; one-hot or zero.
- k_veri_o  out  BLOK_BIT  read data, shared by both requesters.
- k_veri_gecerli_o  out  2  per-requester read-data valid; one-hot or zero.
- k_veri_hazir_i  in  2  per-requester read-data ready.
- vy_istek_adres_o  out  ADRES_BIT  downstream address.
- vy_istek_gecerli_o  out  1  downstream request valid.
- vy_istek_hazir_i  in  1  downstream request ready.
- vy_istek_yaz_o  out  1  downstream write flag.
- vy_istek_veri_o  out  BLOK_BIT  downstream write block.
- vy_veri_i  in  BLOK_BIT  downstream read data.
- vy_veri_gecerli_i  in  1  downstream read-data valid.
- vy_veri_hazir_o  out  1  downstream read-data ready.

Behaviour:
- Handshake: a transfer occurs on any clock edge where valid and ready are both 1. Once a valid is raised it stays high until its handshake; the block relies on this from requesters and guarantees it on its own outputs.
- Registers:
  - durum_r: BOSTA/ISTEK/YANIT.
  - sahip_r (1 bit): current owner.
  - son_sahip_r (1 bit): last owner granted.
  - Latched adres, yaz, veri.
  - vy_istek_gecerli_r.
- Reset (async, rstn_i=0): durum=BOSTA, sahip=0, son_sahip=1 (so l1b wins the first tie). All registered outputs are 0, which forces every output to 0.
- Reset mid-operation: the in-flight transaction is abandoned and no response is delivered. The downstream side shares the same reset.
- BOSTA:
  - Winner g selected combinationally. Only one requester valid: g is that requester. Both valid: g = ~son_sahip_r (round-robin).
  - k_istek_hazir_o[g]=1 only when at least one request is valid; otherwise k_istek_hazir_o=00.
  - On handshake: latch adres/yaz/veri of g, sahip<=g, son_sahip<=g, vy_istek_gecerli<=1, go to ISTEK.
  - A requester that drops valid before handshake is never latched.
- ISTEK:
  - k_istek_hazir_o=00.
  - vy_istek_* outputs are driven from the latched registers and held stable.
  - On the vy_istek handshake: vy_istek_gecerli<=0.
  - Write: go to BOSTA; there is no response for writes.
  - Read: go to YANIT.
- YANIT (pure combinational pass-through, zero added latency):
  - k_veri_o=vy_veri_i.
  - k_veri_gecerli_o[sahip]=vy_veri_gecerli_i; the other bit is 0.
  - vy_veri_hazir_o=k_veri_hazir_i[sahip].
  - On the handshake, go to BOSTA.
- Outside YANIT: k_veri_gecerli_o=00, vy_veri_hazir_o=0, k_veri_o=0.
- Latency and throughput:
  - Request acceptance to vy_istek_gecerli_o=1: 1 cycle.
  - Minimum read: accept at cycle 0, downstream request cycle 1, response cycle 2; the next acceptance is possible at cycle 3.
  - Minimum write: next acceptance 2 cycles after the previous one.
- Ownership does not change in ISTEK or YANIT, even if the other requester is waiting.
- A response arriving while in ISTEK is not possible. vy_veri_gecerli_i outside YANIT is ignored; vy_veri_hazir_o=0.

Optional Feature:
- Macro VY_HAKEM_VERI_ONCELIK_EN.
- Defined: fixed priority. Requester 1 (l1v) always wins when both are valid; son_sahip_r is still updated but not used for selection.
- Undefined: round-robin as described above.

Test Plan:
- Single read from l1b, adres=0x8000_0040:
  - vy_istek_gecerli_o=1 the cycle after acceptance, with vy_istek_yaz_o=0 and address 0x8000_0040.
  - Return vy_veri_i=128'hA5..A5 → k_veri_gecerli_o=01, k_veri_o=A5..A5 in the same cycle.
- Simultaneous valid=11 from reset:
  - l1b is granted first, l1v second.
  - Repeat 4 transactions with both requesters always valid → grant order 0,1,0,1.
  - With VY_HAKEM_VERI_ONCELIK_EN → order 1,1,1,1.
- l1v write, adres=0x0000_1000, veri=128'h1234:
  - Downstream sees yaz=1 and the data.
  - No response phase; k_istek_hazir_o is nonzero again 2 cycles after the first acceptance.
- Backpressure:
  - Hold vy_istek_hazir_i=0 for 5 cycles → vy_istek_* stable and k_istek_hazir_o=00 throughout.
  - Hold k_veri_hazir_i=0 for 3 cycles in YANIT → vy_veri_hazir_o=0 and the block stays in YANIT.
- Drive rstn_i low asynchronously mid-YANIT:
  - All outputs go to 0 immediately.
  - After release, the next tie is granted to l1b.

Source files
------------

// File: rtl/vy_hakem.sv
// Two-requester arbiter (l1b=0, l1v=1) for one memory bus port; one transaction outstanding; 1-cycle accept-to-downstream latency.
// Read responses pass straight through to the owner. Backpressure holds the block in ISTEK or YANIT.
// VY_HAKEM_VERI_ONCELIK_EN selects fixed l1v priority on ties; the default is round-robin.
module vy_hakem #(
  parameter int ADRES_BIT = 32,
  parameter int BLOK_BIT  = 128
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [2*ADRES_BIT-1:0] k_istek_adres_i,
  input  logic [1:0]            k_istek_gecerli_i,
  input  logic [1:0]            k_istek_yaz_i,
  input  logic [2*BLOK_BIT-1:0] k_istek_veri_i,
  output logic [1:0]            k_istek_hazir_o,
  output logic [BLOK_BIT-1:0]   k_veri_o,
  output logic [1:0]            k_veri_gecerli_o,
  input  logic [1:0]            k_veri_hazir_i,
  output logic [ADRES_BIT-1:0]  vy_istek_adres_o,
  output logic                  vy_istek_gecerli_o,
  input  logic                  vy_istek_hazir_i,
  output logic                  vy_istek_yaz_o,
  output logic [BLOK_BIT-1:0]   vy_istek_veri_o,
  input  logic [BLOK_BIT-1:0]   vy_veri_i,
  input  logic                  vy_veri_gecerli_i,
  output logic                  vy_veri_hazir_o
);

  typedef enum logic [1:0] {BOSTA, ISTEK, YANIT} durum_t;

  durum_t               durum_q, durum_d;
  logic                 sahip_q, sahip_d;
  logic                 son_sahip_q, son_sahip_d;
  logic [ADRES_BIT-1:0] adres_q, adres_d;
  logic                 yaz_q, yaz_d;
  logic [BLOK_BIT-1:0]  veri_q, veri_d;
  logic                 vy_istek_gecerli_q, vy_istek_gecerli_d;

  logic g;
  logic herhangi;

  always_comb begin
    g = 1'b0;
    case (k_istek_gecerli_i)
      2'b01:   g = 1'b0;
      2'b10:   g = 1'b1;
`ifdef VY_HAKEM_VERI_ONCELIK_EN
      2'b11:   g = 1'b1;
`else
      2'b11:   g = ~son_sahip_q;
`endif
      default: g = 1'b0;
    endcase
    herhangi = |k_istek_gecerli_i;
  end

  always_comb begin
    durum_d            = durum_q;
    sahip_d            = sahip_q;
    son_sahip_d        = son_sahip_q;
    adres_d            = adres_q;
    yaz_d              = yaz_q;
    veri_d             = veri_q;
    vy_istek_gecerli_d = vy_istek_gecerli_q;
    k_istek_hazir_o    = 2'b00;
    k_veri_o           = '0;
    k_veri_gecerli_o   = 2'b00;
    vy_veri_hazir_o    = 1'b0;

    case (durum_q)
      BOSTA: begin
        // Ready is gated by reset so every output is low while rstn_i is asserted.
        if (herhangi && rstn_i) begin
          k_istek_hazir_o[g] = 1'b1;
          adres_d            = k_istek_adres_i[g*ADRES_BIT +: ADRES_BIT];
          yaz_d              = k_istek_yaz_i[g];
          veri_d             = k_istek_veri_i[g*BLOK_BIT +: BLOK_BIT];
          sahip_d            = g;
          son_sahip_d        = g;
          vy_istek_gecerli_d = 1'b1;
          durum_d            = ISTEK;
        end
      end
      ISTEK: begin
        if (vy_istek_hazir_i) begin
          vy_istek_gecerli_d = 1'b0;
          durum_d            = yaz_q ? BOSTA : YANIT;
        end
      end
      YANIT: begin
        k_veri_o                  = vy_veri_i;
        k_veri_gecerli_o[sahip_q] = vy_veri_gecerli_i;
        vy_veri_hazir_o           = k_veri_hazir_i[sahip_q];
        if (vy_veri_gecerli_i && k_veri_hazir_i[sahip_q]) durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q            <= BOSTA;
      sahip_q            <= 1'b0;
      son_sahip_q        <= 1'b1;
      adres_q            <= '0;
      yaz_q              <= 1'b0;
      veri_q             <= '0;
      vy_istek_gecerli_q <= 1'b0;
    end else begin
      durum_q            <= durum_d;
      sahip_q            <= sahip_d;
      son_sahip_q        <= son_sahip_d;
      adres_q            <= adres_d;
      yaz_q              <= yaz_d;
      veri_q             <= veri_d;
      vy_istek_gecerli_q <= vy_istek_gecerli_d;
    end
  end

  assign vy_istek_adres_o   = adres_q;
  assign vy_istek_yaz_o     = yaz_q;
  assign vy_istek_veri_o    = veri_q;
  assign vy_istek_gecerli_o = vy_istek_gecerli_q;

endmodule

// File: tb/tb_vy_hakem.sv
// Directed bench for vy_hakem: read, tie arbitration, write, backpressure and async reset.
module tb_vy_hakem;
  localparam int AB = 32;
  localparam int BB = 128;

  logic            clk_i = 1'b0;
  logic            rstn_i = 1'b0;
  logic [2*AB-1:0] k_istek_adres_i = '0;
  logic [1:0]      k_istek_gecerli_i = '0;
  logic [1:0]      k_istek_yaz_i = '0;
  logic [2*BB-1:0] k_istek_veri_i = '0;
  logic [1:0]      k_istek_hazir_o;
  logic [BB-1:0]   k_veri_o;
  logic [1:0]      k_veri_gecerli_o;
  logic [1:0]      k_veri_hazir_i = '0;
  logic [AB-1:0]   vy_istek_adres_o;
  logic            vy_istek_gecerli_o;
  logic            vy_istek_hazir_i = 1'b1;
  logic            vy_istek_yaz_o;
  logic [BB-1:0]   vy_istek_veri_o;
  logic [BB-1:0]   vy_veri_i = '0;
  logic            vy_veri_gecerli_i = 1'b0;
  logic            vy_veri_hazir_o;

  int checks = 0;
  int failures = 0;

  vy_hakem #(.ADRES_BIT(AB), .BLOK_BIT(BB)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .k_istek_adres_i(k_istek_adres_i), .k_istek_gecerli_i(k_istek_gecerli_i),
    .k_istek_yaz_i(k_istek_yaz_i), .k_istek_veri_i(k_istek_veri_i),
    .k_istek_hazir_o(k_istek_hazir_o), .k_veri_o(k_veri_o),
    .k_veri_gecerli_o(k_veri_gecerli_o), .k_veri_hazir_i(k_veri_hazir_i),
    .vy_istek_adres_o(vy_istek_adres_o), .vy_istek_gecerli_o(vy_istek_gecerli_o),
    .vy_istek_hazir_i(vy_istek_hazir_i), .vy_istek_yaz_o(vy_istek_yaz_o),
    .vy_istek_veri_o(vy_istek_veri_o), .vy_veri_i(vy_veri_i),
    .vy_veri_gecerli_i(vy_veri_gecerli_i), .vy_veri_hazir_o(vy_veri_hazir_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hazir"}, k_istek_hazir_o, 0);
    check({tag, "_vgec"}, vy_istek_gecerli_o, 0);
    check({tag, "_kvgec"}, k_veri_gecerli_o, 0);
    check({tag, "_kveri"}, k_veri_o, 0);
    check({tag, "_vyhaz"}, vy_veri_hazir_o, 0);
    check({tag, "_vadr"}, vy_istek_adres_o, 0);
    check({tag, "_vyaz"}, vy_istek_yaz_o, 0);
    check({tag, "_vveri"}, vy_istek_veri_o, 0);
  endtask

  logic [1:0]    tie_first;
  logic [127:0]  a5;
  logic [127:0]  pat;
  logic          exp_r;

  initial begin
`ifdef VY_HAKEM_VERI_ONCELIK_EN
    tie_first = 2'b10;
`else
    tie_first = 2'b01;
`endif
    a5  = {16{8'hA5}};
    pat = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

    #12;
    check_all_zero("rst");
    #10;
    rstn_i = 1'b1;
    tick;

    // Tie from reset: both valid writes, all four transactions back to back.
    k_istek_adres_i = {32'h0000_0200, 32'h0000_0100};
    k_istek_yaz_i   = 2'b11;
    k_istek_gecerli_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef VY_HAKEM_VERI_ONCELIK_EN
      exp_r = 1'b1;
`else
      exp_r = i[0];
`endif
      #1;
      check($sformatf("tie%0d_grant", i), k_istek_hazir_o, exp_r ? 2'b10 : 2'b01);
      tick;
      check($sformatf("tie%0d_adr", i), vy_istek_adres_o, exp_r ? 32'h200 : 32'h100);
      check($sformatf("tie%0d_busy", i), k_istek_hazir_o, 2'b00);
      tick;
    end
    k_istek_gecerli_i = 2'b00;
    k_istek_yaz_i = 2'b00;
    tick;

    // Single l1b read with same-cycle response pass-through.
    k_istek_adres_i[31:0] = 32'h8000_0040;
    k_istek_gecerli_i = 2'b01;
    #1;
    check("rd_hazir", k_istek_hazir_o, 2'b01);
    tick;
    k_istek_gecerli_i = 2'b00;
    #1;
    check("rd_vgec", vy_istek_gecerli_o, 1);
    check("rd_vyaz", vy_istek_yaz_o, 0);
    check("rd_vadr", vy_istek_adres_o, 32'h8000_0040);
    tick;
    check("rd_vgec_drop", vy_istek_gecerli_o, 0);
    vy_veri_i = a5;
    vy_veri_gecerli_i = 1'b1;
    k_veri_hazir_i = 2'b11;
    #1;
    check("rd_kvgec", k_veri_gecerli_o, 2'b01);
    check("rd_kveri", k_veri_o, a5);
    check("rd_vyhaz", vy_veri_hazir_o, 1);
    tick;
    vy_veri_gecerli_i = 1'b0;
    #1;
    check("rd_done_kvgec", k_veri_gecerli_o, 2'b00);
    check("rd_done_kveri", k_veri_o, 0);

    // l1v write: no response phase, ready again two cycles after acceptance.
    k_istek_adres_i[63:32] = 32'h0000_1000;
    k_istek_veri_i[255:128] = 128'h1234;
    k_istek_yaz_i = 2'b10;
    k_istek_gecerli_i = 2'b10;
    #1;
    check("wr_hazir", k_istek_hazir_o, 2'b10);
    tick;
    check("wr_vyaz", vy_istek_yaz_o, 1);
    check("wr_vveri", vy_istek_veri_o, 128'h1234);
    check("wr_vadr", vy_istek_adres_o, 32'h1000);
    check("wr_vgec", vy_istek_gecerli_o, 1);
    tick;
    check("wr_again", k_istek_hazir_o, 2'b10);
    check("wr_nokvgec", k_veri_gecerli_o, 2'b00);
    k_istek_gecerli_i = 2'b00;
    k_istek_yaz_i = 2'b00;
    tick;

    // Downstream request backpressure; a competing requester must not steal ownership.
    vy_istek_hazir_i = 1'b0;
    k_istek_gecerli_i = 2'b01;
    #1;
    check("bp_hazir", k_istek_hazir_o, 2'b01);
    tick;
    k_istek_gecerli_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d_vgec", i), vy_istek_gecerli_o, 1);
      check($sformatf("bp%0d_vadr", i), vy_istek_adres_o, 32'h8000_0040);
      check($sformatf("bp%0d_hazir", i), k_istek_hazir_o, 2'b00);
      tick;
    end
    vy_istek_hazir_i = 1'b1;
    tick;

    // Response backpressure in YANIT.
    k_veri_hazir_i = 2'b00;
    vy_veri_i = pat;
    vy_veri_gecerli_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rbp%0d_vyhaz", i), vy_veri_hazir_o, 0);
      check($sformatf("rbp%0d_kvgec", i), k_veri_gecerli_o, 2'b01);
      check($sformatf("rbp%0d_kveri", i), k_veri_o, pat);
      tick;
    end
    k_veri_hazir_i = 2'b01;
    #1;
    check("rbp_vyhaz", vy_veri_hazir_o, 1);

    // Asynchronous reset in the middle of YANIT.
    #1;
    rstn_i = 1'b0;
    #1;
    check_all_zero("arst");
    tick;
    #2;
    rstn_i = 1'b1;
    vy_veri_gecerli_i = 1'b0;
    #1;
    check("arst_kvgec", k_veri_gecerli_o, 2'b00);
    check("arst_tie", k_istek_hazir_o, tie_first);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
